shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Multicycle variable-amount shifter controller for the CPU datapath. It accepts a word, shift op and shift amount over a valid/ready handshake. It then drives a 1-bit shift stage once per cycle for shamt cycles and presents the result over a valid/ready handshake. It provides SLL/SRL/SRA without a full barrel shifter, for the multicycle ALU path.

Parameters:
WIDTH, 16, data word width in bits (power of 2, >= 4)
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start_valid  input  1  request present
start_ready  output  1  sequencer can accept request (high only in IDLE)
op  input  2  00=SLL, 01=SRL, 10=SRA, 11=illegal
shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
din  input  WIDTH  operand
result  output  WIDTH  shifted result, registered
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
op_err  output  1  illegal op flag, valid only with result_valid
busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset on a clk edge with reset=1:
  - state=IDLE; data, count, result=0.
  - result_valid=0, op_err=0, busy=0.
  - start_ready=1 from the first cycle after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - Accept when start_valid && start_ready: latch din->data, op->op_r, shamt->count.
  - Next state: DONE if shamt==0 or op==11, else SHIFT.
- SHIFT:
  - Each cycle: data <= step(data, op_r); count <= count-1.
  - When count==1 this cycle, next state is DONE.
  - Exactly shamt step cycles are performed.
- step(), per op:
  - SLL: {data[WIDTH-2:0],1'b0}
  - SRL: {1'b0,data[WIDTH-1:1]}
  - SRA: {data[WIDTH-1],data[WIDTH-1:1]}, sign of the current data.
- DONE:
  - result=data; result_valid=1; op_err=(op_r==11).
  - Hold result, result_valid and op_err stable until result_ready=1.
  - On that edge: result_valid<=0, next state IDLE. result keeps its value; op_err<=0.
- Latency: accept edge to result_valid high = max(shamt,0)+1 cycles.
  - shamt=0 gives 1 cycle; shamt=15 gives 16 cycles.
- Throughput: the next request is accepted no earlier than the cycle after result handshake.
- Illegal op (11): no shifting; result=din; op_err=1; 1-cycle latency.
- start_valid while not IDLE: ignored (start_ready=0); no latch, no state change.
- din/op/shamt changing after accept: no effect.
- result_ready while not DONE: ignored.
- Reset mid-operation (SHIFT or DONE): abandon, go to IDLE next edge; pending result discarded; all outputs take reset values.
- Widths:
  - Shifts are logical within WIDTH; bits shifted out are lost.
  - No carry/overflow output.
  - shamt cannot exceed WIDTH-1 by construction.

Decomposition:
- Package shift_seq_pkg:
  - Op encodings as typedef enum logic [1:0] shift_op_t: SH_SLL, SH_SRL, SH_SRA, SH_BAD.
  - FSM typedef enum seq_state_t: S_IDLE, S_SHIFT, S_DONE.
- Sub-module shift1_stage (WIDTH parameter): purely combinational single-step shifter for all three ops. It reuses the existing shift-left-by-SHIFT module with SHIFT=1 for the SLL leg.
- shift_sequencer holds the FSM, count register, data register and handshakes.

Test Plan:
- SLL, din=16'h0001, shamt=4, result_ready=1 -> result=16'h0010, result_valid rises 5 cycles after accept, single cycle pulse, op_err=0.
- SRA din=16'h8000 shamt=15 -> 16'hFFFF after 16 cycles; repeat with SRL -> 16'h0001; SRA din=16'h4000 shamt=2 -> 16'h1000.
- shamt=0, op=SLL, din=16'hBEEF -> result=16'hBEEF, result_valid 1 cycle after accept; op=11, din=16'h1234 -> result=16'h1234, op_err=1, 1-cycle latency.
- Backpressure: SLL din=16'h0003 shamt=1, hold result_ready=0 for 3 cycles and pulse start_valid with new data -> result stays 16'h0006, result_valid stays 1, start_ready=0, new request not latched; result_ready=1 -> IDLE next cycle.
- Reset mid-shift: SRL din=16'hFF00 shamt=8, assert reset on 3rd SHIFT cycle -> next edge IDLE, result=0, result_valid=0, busy=0, start_ready=1. Then SRL shamt=8 completes -> 16'h00FF.
- Back-to-back: two requests (SLL 16'h0001 shamt=1; SRA 16'hF000 shamt=4) with start_valid held -> second accepted the cycle after first handshake; results 16'h0002 then 16'hFF00.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types for the multicycle shift sequencer: op encodings and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package shift_seq_pkg;

    // Shift operation encodings as carried on the op port
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_BAD = 2'b11
    } shift_op_t;

    // Sequencer control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } seq_state_t;

    // An op that performs no shifting and completes immediately with an error flag
    function automatic logic is_bad_op(input shift_op_t o);
        return (o == SH_BAD);
    endfunction

endpackage

// File: rtl/shift1_stage.sv
// Single-bit shift step for SLL/SRL/SRA; illegal op passes data through unchanged.
// Latency: combinational.
// Backpressure: none.
module shift1_stage
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sll_dat;

    shift_left #(
        .WIDTH (WIDTH),
        .SHIFT (1)
    ) u_sll (
        .din  (data),
        .dout (sll_dat)
    );

    // Select the one-bit step for the requested op; SRA replicates the current sign bit
    always_comb begin
        dout = data;
        case (op)
            SH_SLL:  dout = sll_dat;
            SH_SRL:  dout = {1'b0, data[WIDTH-1:1]};
            SH_SRA:  dout = {data[WIDTH-1], data[WIDTH-1:1]};
            default: dout = data;
        endcase
    end

endmodule

// File: rtl/shift_left.sv
// Constant shift-left by SHIFT bit positions, zero fill; bits shifted out are lost.
// Latency: combinational.
// Backpressure: none.
module shift_left #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = din << SHIFT;

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle SLL/SRL/SRA controller: one bit per cycle for shamt cycles, then result handshake.
// Latency: accept edge to result_valid = shamt+1 cycles (1 cycle for shamt=0 or illegal op).
// Backpressure: result held until result_ready; start_ready only in IDLE, so new work waits for the result handshake.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               op_err,
    output logic               busy
);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   step_dat;
    logic [SHAMT_W-1:0] count;
    shift_op_t          op_r;
    shift_op_t          op_in;
    logic               accept;
    logic               last_step;
    logic               res_hs;

    assign op_in     = shift_op_t'(op);
    assign accept    = start_valid && start_ready;
    assign last_step = (count == SHAMT_W'(1));
    assign res_hs    = result_valid && result_ready;

    shift1_stage #(
        .WIDTH (WIDTH)
    ) u_step (
        .data (data),
        .op   (op_r),
        .dout (step_dat)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: zero shift or illegal op skips straight to DONE; DONE leaves only on the result handshake
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if ((shamt == '0) || is_bad_op(op_in)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (res_hs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state outputs: request side is open only while idle
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE:  start_ready = 1'b1;
            S_SHIFT: busy        = 1'b1;
            S_DONE:  busy        = 1'b1;
            default: begin
                start_ready = 1'b0;
                busy        = 1'b0;
            end
        endcase
    end

    // Working registers: capture the request on accept, then take one shift step per SHIFT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
            op_r  <= SH_SLL;
        end else begin
            if (state == S_IDLE) begin
                if (accept) begin
                    data  <= din;
                    count <= shamt;
                    op_r  <= op_in;
                end
            end else if (state == S_SHIFT) begin
                data  <= step_dat;
                count <= count - 1'b1;
            end
        end
    end

    // Result registers: load once on the first DONE cycle, hold until consumed; result keeps its value afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            op_err       <= 1'b0;
        end else if (state == S_DONE) begin
            if (!result_valid) begin
                result       <= data;
                result_valid <= 1'b1;
                op_err       <= is_bad_op(op_r);
            end else if (result_ready) begin
                result_valid <= 1'b0;
                op_err       <= 1'b0;
            end
        end
    end

endmodule
